mem_ctrl: RTL and testbench

- Byte-serial memory controller; the responder side of the instruction-fetch request/done handshake.
- Also serves load/store requests from the LSB.
- Sits between the core (IFetch, LSB) and the single-port byte-wide RAM.
- Arbitrates between the two requestors and assembles or splits multi-byte little-endian transfers.

---
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - core/RAM side bus bundle of the byte-serial memory controller
// Ports (slave = controller view):
//   if_en, if_pc            fetch request, held until if_done
//   if_done, if_data        fetch done pulse and block, byte 0 in LSBs
//   lsb_en, lsb_wr, lsb_len load/store request, held until lsb_done
//   lsb_addr, lsb_w_data    load/store address and little-endian store data
//   lsb_done, lsb_r_data    load/store done pulse and zero-extended load data
//   mem_din                 RAM read byte (one cycle after mem_a is sampled)
//   mem_dout, mem_a, mem_wr RAM write byte, byte address, write strobe
interface mem_ctrl_if #(
  parameter int IF_BLK_BYTES = 4,
  parameter int ADDR_W       = 32
);
  logic                      if_en;
  logic [ADDR_W-1:0]         if_pc;
  logic                      if_done;
  logic [8*IF_BLK_BYTES-1:0] if_data;
  logic                      lsb_en;
  logic                      lsb_wr;
  logic [2:0]                lsb_len;
  logic [ADDR_W-1:0]         lsb_addr;
  logic [31:0]               lsb_w_data;
  logic                      lsb_done;
  logic [31:0]               lsb_r_data;
  logic [7:0]                mem_din;
  logic [7:0]                mem_dout;
  logic [ADDR_W-1:0]         mem_a;
  logic                      mem_wr;

  modport master (
    output if_en, if_pc, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data, mem_din,
    input  if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data, mem_din,
    output if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating IFetch and LSB onto a byte RAM
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-low reset
//   rdy       global enable; low freezes every register
//   rollback  aborts an in-flight load (fetches and stores are unaffected)
//   bus       mem_ctrl_if.slave: fetch, load/store and RAM signals
module mem_ctrl #(
  parameter int IF_BLK_BYTES = 4,
  parameter int ADDR_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rollback,
  mem_ctrl_if.slave  bus
);

  localparam int CNT_W = 8;
  localparam int IF_W  = 8 * IF_BLK_BYTES;

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, COOL} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0]    nbytes, nbytes_n;
  logic [31:0]         wdata, wdata_n;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_n;
  logic [7:0]          dout_q, dout_n;
  logic                wr_q, wr_n;
  logic                if_done_q, if_done_n;
  logic                lsb_done_q, lsb_done_n;
  logic [IF_W-1:0]     if_data_q, if_data_n;
  logic [31:0]         r_data_q, r_data_n;

  function automatic logic [CNT_W-1:0] len_bytes(input logic [2:0] len);
    case (len)
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  always_comb begin
    int idx;
    state_n    = state;
    cnt_n      = cnt;
    nbytes_n   = nbytes;
    wdata_n    = wdata;
    mem_a_n    = mem_a_q;
    dout_n     = dout_q;
    wr_n       = wr_q;
    if_data_n  = if_data_q;
    r_data_n   = r_data_q;
    if_done_n  = 1'b0;
    lsb_done_n = 1'b0;
    idx        = int'(cnt) - 1;

    case (state)
      IDLE: begin
        if (bus.lsb_en) begin
          state_n  = bus.lsb_wr ? LS_WR : LS_RD;
          nbytes_n = len_bytes(bus.lsb_len);
          cnt_n    = '0;
          mem_a_n  = bus.lsb_addr;
          wdata_n  = bus.lsb_w_data;
          if (bus.lsb_wr) begin
            dout_n = bus.lsb_w_data[7:0];
            wr_n   = 1'b1;
          end else begin
            // upper bytes of short loads must read back as zero
            r_data_n = '0;
          end
        end else if (bus.if_en) begin
          state_n  = IF_RD;
          nbytes_n = CNT_W'(IF_BLK_BYTES);
          cnt_n    = '0;
          mem_a_n  = bus.if_pc;
        end
      end

      IF_RD, LS_RD: begin
        if (state == LS_RD && rollback) begin
          state_n = COOL;
        end else begin
          // cnt = edges seen since acceptance; mem_din holds byte cnt-1
          cnt_n   = cnt + CNT_W'(1);
          mem_a_n = mem_a_q + ADDR_W'(1);
          if (cnt != '0) begin
            if (state == IF_RD) if_data_n[8*idx +: 8] = bus.mem_din;
            else                r_data_n[8*idx +: 8]  = bus.mem_din;
          end
          if (cnt == nbytes) begin
            state_n = COOL;
            if (state == IF_RD) if_done_n  = 1'b1;
            else                lsb_done_n = 1'b1;
          end
        end
      end

      LS_WR: begin
        // byte cnt is being written at this edge
        if (cnt + CNT_W'(1) == nbytes) begin
          wr_n       = 1'b0;
          lsb_done_n = 1'b1;
          state_n    = COOL;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          mem_a_n = mem_a_q + ADDR_W'(1);
          dout_n  = wdata[8*(int'(cnt)+1) +: 8];
        end
      end

      // requestor is still dropping en this cycle, so ignore it
      COOL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      nbytes     <= '0;
      wdata      <= '0;
      mem_a_q    <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      if_data_q  <= '0;
      r_data_q   <= '0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      nbytes     <= nbytes_n;
      wdata      <= wdata_n;
      mem_a_q    <= mem_a_n;
      dout_q     <= dout_n;
      wr_q       <= wr_n;
      if_done_q  <= if_done_n;
      lsb_done_q <= lsb_done_n;
      if_data_q  <= if_data_n;
      r_data_q   <= r_data_n;
    end
  end

  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.lsb_r_data = r_data_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_wr     = wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed vector bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;

  logic clk;
  logic rst;
  logic rdy;
  logic rollback;

  mem_ctrl_if #(.IF_BLK_BYTES(4), .ADDR_W(32)) bus ();

  mem_ctrl #(.IF_BLK_BYTES(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte RAM, low 12 address bits, frozen with the rest of the system when rdy is low
  logic [7:0] ram [0:4095];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) begin
        ram[bus.mem_a[11:0]] <= bus.mem_dout;
        wr_cnt <= wr_cnt + 1;
      end
      bus.mem_din <= ram[bus.mem_a[11:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // counts edges until the selected done is seen; -1 on timeout
  task automatic wait_done(input bit is_if, input bit scramble,
                           output int edges, output logic [31:0] data);
    edges = -1;
    data  = '0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 1 && scramble) begin
        bus.if_pc      = 32'hDEAD_BEE0;
        bus.lsb_addr   = 32'hDEAD_BEE0;
        bus.lsb_w_data = 32'h0BAD_0BAD;
        bus.lsb_len    = 3'd1;
      end
      if (is_if ? bus.if_done : bus.lsb_done) begin
        edges = i;
        data  = is_if ? bus.if_data : bus.lsb_r_data;
        return;
      end
    end
  endtask

  typedef struct {
    int          kind;       // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;        // read data, or RAM word at addr after a store
    int          exp_edges;  // edges from raising en to seeing done
  } vec_t;

  vec_t vt [8];

  function automatic int nb(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  initial begin
    int          edges;
    int          w0;
    int          seen;
    logic [31:0] data;
    logic [11:0] a;

    vt[0] = '{0, 32'h0000_0100, 3'd0, 32'h0,          32'h0000_0513, 6};
    vt[1] = '{2, 32'h0000_0200, 3'd2, 32'hAABB_CCDD, 32'hEEEE_CCDD, 3};
    vt[2] = '{1, 32'h0000_0200, 3'd2, 32'h0,          32'h0000_CCDD, 4};
    vt[3] = '{2, 32'h0000_0300, 3'd4, 32'h1234_5678, 32'h1234_5678, 5};
    vt[4] = '{1, 32'h0000_0300, 3'd3, 32'h0,          32'h1234_5678, 6};
    vt[5] = '{1, 32'h0000_0301, 3'd1, 32'h0,          32'h0000_0056, 3};
    vt[6] = '{0, 32'hFFFF_FFFE, 3'd0, 32'h0,          32'h4433_2211, 6};
    vt[7] = '{1, 32'hFFFF_FFFF, 3'd4, 32'h0,          32'h0044_3322, 6};

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    ram[12'h010] = 8'h7F;
    ram[12'h202] = 8'hEE; ram[12'h203] = 8'hEE;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22;
    ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = 3'd1;
    bus.lsb_addr = '0; bus.lsb_w_data = '0;
    repeat (2) step();
    check("rst_if_done",  bus.if_done,    0);
    check("rst_lsb_done", bus.lsb_done,   0);
    check("rst_mem_wr",   bus.mem_wr,     0);
    check("rst_mem_a",    bus.mem_a,      0);
    check("rst_mem_dout", bus.mem_dout,   0);
    check("rst_if_data",  bus.if_data,    0);
    check("rst_r_data",   bus.lsb_r_data, 0);
    rst = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      w0 = wr_cnt;
      if (vt[v].kind == 0) begin
        bus.if_en = 1'b1; bus.if_pc = vt[v].addr;
      end else begin
        bus.lsb_en = 1'b1; bus.lsb_wr = (vt[v].kind == 2);
        bus.lsb_len = vt[v].len; bus.lsb_addr = vt[v].addr; bus.lsb_w_data = vt[v].wdata;
      end
      wait_done(vt[v].kind == 0, 1'b1, edges, data);
      bus.if_en = 1'b0; bus.lsb_en = 1'b0;
      check($sformatf("v%0d_latency", v), edges, vt[v].exp_edges);
      if (vt[v].kind != 2) begin
        check($sformatf("v%0d_data", v), data, vt[v].exp);
        check($sformatf("v%0d_no_write", v), wr_cnt - w0, 0);
      end else begin
        a = vt[v].addr[11:0];
        check($sformatf("v%0d_write_count", v), wr_cnt - w0, nb(vt[v].len));
        check($sformatf("v%0d_ram", v),
              {ram[a+12'd3], ram[a+12'd2], ram[a+12'd1], ram[a]}, vt[v].exp);
      end
      step();
      check($sformatf("v%0d_pulse_len", v), bus.if_done | bus.lsb_done, 0);
    end

    // contention: LSB wins, fetch follows after COOL
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 3'd1; bus.lsb_addr = 32'h10;
    wait_done(1'b0, 1'b0, edges, data);
    bus.lsb_en = 1'b0;
    check("cont_lsb_latency", edges, 3);
    check("cont_lsb_data", data, 32'h0000_007F);
    check("cont_if_not_yet", bus.if_done, 0);
    wait_done(1'b1, 1'b0, edges, data);
    bus.if_en = 1'b0;
    check("cont_if_latency", edges, 7);
    check("cont_if_data", data, 32'h0000_0513);
    step();

    // rollback during a load: no done, back to IDLE
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 3'd4; bus.lsb_addr = 32'h100;
    step(); step();
    rollback = 1'b1; bus.lsb_en = 1'b0;
    step();
    rollback = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.lsb_done) seen++;
      step();
    end
    check("rb_no_done", seen, 0);
    bus.lsb_en = 1'b1; bus.lsb_len = 3'd1; bus.lsb_addr = 32'h10;
    wait_done(1'b0, 1'b0, edges, data);
    bus.lsb_en = 1'b0;
    check("rb_next_latency", edges, 3);
    check("rb_next_data", data, 32'h0000_007F);
    step();

    // rollback is ignored by a fetch
    rollback = 1'b1;
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    wait_done(1'b1, 1'b0, edges, data);
    bus.if_en = 1'b0; rollback = 1'b0;
    check("rb_if_latency", edges, 6);
    check("rb_if_data", data, 32'h0000_0513);
    step();

    // rdy low for 3 cycles mid-store
    w0 = wr_cnt;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 3'd4;
    bus.lsb_addr = 32'h400; bus.lsb_w_data = 32'hCAFE_F00D;
    step(); step();
    rdy = 1'b0;
    repeat (3) step();
    check("rdy_wr_held", bus.mem_wr, 1);
    rdy = 1'b1;
    wait_done(1'b0, 1'b0, edges, data);
    bus.lsb_en = 1'b0;
    check("rdy_latency", edges, 3);
    check("rdy_write_count", wr_cnt - w0, 4);
    check("rdy_ram", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, 32'hCAFE_F00D);
    step();

    // asynchronous reset mid-fetch, then the held request restarts from IDLE
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    repeat (4) step();
    rst = 1'b0;
    #1;
    check("arst_if_done", bus.if_done, 0);
    check("arst_mem_wr",  bus.mem_wr,  0);
    check("arst_mem_a",   bus.mem_a,   0);
    check("arst_if_data", bus.if_data, 0);
    rst = 1'b1;
    wait_done(1'b1, 1'b0, edges, data);
    bus.if_en = 1'b0;
    check("arst_refetch_latency", edges, 6);
    check("arst_refetch_data", data, 32'h0000_0513);
    step();

    // asynchronous reset mid-store drops the write strobe at once
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 3'd4;
    bus.lsb_addr = 32'h500; bus.lsb_w_data = 32'h0102_0304;
    step();
    check("st_wr_active", bus.mem_wr, 1);
    rst = 1'b0;
    #1;
    check("arst_st_mem_wr",   bus.mem_wr,   0);
    check("arst_st_lsb_done", bus.lsb_done, 0);
    bus.lsb_en = 1'b0;
    rst = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
